// File: rtl/aes128_inv_cipher_iter.sv
// ---------------------------------------------------------------------------
// aes128_inv_cipher_iter
//   Iterative AES-128 decryption core. One ciphertext block is accepted in
//   IDLE, one inverse round is computed per clock, and the plaintext is held
//   in DONE until the sink takes it. Round keys are fetched combinationally
//   from an external expanded-key store through rk_idx / round_key.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   ct_in carries a ciphertext block
//   in_ready   core can accept a block (IDLE only)
//   ct_in      ciphertext, [127:120] = s0, bytes column-major
//   rk_idx     round-key index requested this cycle
//   round_key  expanded-key word selected by rk_idx (same cycle)
//   out_valid  pt_out carries a plaintext block
//   out_ready  sink accepts pt_out
//   pt_out     plaintext, same byte ordering as ct_in
// ---------------------------------------------------------------------------

// Inverse S-box ROM: one byte lookup, purely combinational.
module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Entry 0x00 sits in the top byte, so entry x lives at bit offset 8*(255-x),
  // which for an 8-bit x is simply {~x, 3'b000}.
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign y = INV_SBOX_TBL[{~a, 3'b000} +: 8];

endmodule

module aes128_inv_cipher_iter #(
  parameter int NR       = 10,
  parameter int RK_IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        ct_in,
  output logic [RK_IDX_W-1:0] rk_idx,
  input  logic [127:0]        round_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        pt_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] blk_q, blk_d;
  logic         out_valid_q, out_valid_d;
  logic [127:0] pt_q, pt_d;

  logic [127:0] sr;    // InvShiftRows(blk_q)
  logic [127:0] sb;    // InvSubBytes(sr)
  logic [127:0] t;     // after AddRoundKey
  logic [127:0] imc;   // InvMixColumns(t)

  // GF(2^8) multiply by x, reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through the [0e 0b 0d 09] circulant; col[31:24] is row 0.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4], mb [4], md [4], me [4];
    logic [7:0] x2, x4, x8;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      x2    = xtime(a[r]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[r] = x8 ^ a[r];
      mb[r] = x8 ^ x2 ^ a[r];
      md[r] = x8 ^ x4 ^ a[r];
      me[r] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Byte i sits at row i%4, column i/4. Row r rotates right by r, so the
  // destination (r,c) takes the source byte at (r, (c-r) mod 4).
  for (genvar i = 0; i < 16; i++) begin : g_bytes
    localparam int ROW = i % 4;
    localparam int COL = i / 4;
    localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);

    assign sr[127-8*i -: 8] = blk_q[127-8*SRC -: 8];

    aes_inv_sbox u_inv_sbox (
      .a (sr[127-8*i -: 8]),
      .y (sb[127-8*i -: 8])
    );
  end

  assign t = sb ^ round_key;

  for (genvar c = 0; c < 4; c++) begin : g_cols
    assign imc[127-32*c -: 32] = inv_mix_col(t[127-32*c -: 32]);
  end

  // Key schedule is walked backwards: the whitening key (NR) is used at
  // accept time, then NR-1 down to 0 during the rounds.
  assign rk_idx    = (state_q == S_ROUND) ? RK_IDX_W'(cnt_q) : RK_IDX_W'(NR);
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign pt_out    = pt_q;

  always_comb begin
    // NOTE: every *_d gets its hold value first, so branches that do not
    // assign a signal cannot infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    blk_d       = blk_q;
    out_valid_d = out_valid_q;
    pt_d        = pt_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          blk_d   = ct_in ^ round_key;
          cnt_d   = 4'(NR - 1);
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (cnt_q != 4'd0) begin
          blk_d = imc;
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Final round skips InvMixColumns.
          pt_d        = t;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // NOTE: the datapath registers are reset along with the control, because
  // pt_out is architecturally visible and must read zero out of reset; an
  // abandoned block must never leak through.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      blk_q       <= '0;
      out_valid_q <= 1'b0;
      pt_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      blk_q       <= blk_d;
      out_valid_q <= out_valid_d;
      pt_q        <= pt_d;
    end
  end

endmodule

// File: tb/tb_aes128_inv_cipher_iter.sv
// ---------------------------------------------------------------------------
// tb_aes128_inv_cipher_iter
//   Self-checking bench for aes128_inv_cipher_iter. The bench owns the
//   expanded-key store and a forward AES-128 model (S-box derived from the
//   GF(2^8) inverse plus affine map); random plaintexts are encrypted by the
//   model and the DUT must recover them. Expected plaintexts are queued on
//   accept and popped on each output handshake.
// ---------------------------------------------------------------------------
module tb_aes128_inv_cipher_iter;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ct_in;
  logic [3:0]   rk_idx;
  logic [127:0] round_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] pt_out;

  aes128_inv_cipher_iter #(.NR(10), .RK_IDX_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct_in     (ct_in),
    .rk_idx    (rk_idx),
    .round_key (round_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt_out    (pt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_err = 0;
  int           n_out = 0;
  logic [127:0] exp_q [$];
  logic [127:0] drv_exp;
  logic [127:0] rk_mem [0:10];
  logic [7:0]   sbox_tbl [256];

  assign round_key = (rk_idx <= 4'd10) ? rk_mem[rk_idx] : '0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox_tbl[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                      ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_tbl[tmp[31:24]], sbox_tbl[tmp[23:16]],
               sbox_tbl[tmp[15:8]], sbox_tbl[tmp[7:0]]} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [127:0] s, t;
    logic [7:0]   a0, a1, a2, a3;
    int           row, col;
    s = pt ^ rk_mem[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[8*(15-i) +: 8] = sbox_tbl[s[8*(15-i) +: 8]];
      for (int i = 0; i < 16; i++) begin
        row = i % 4;
        col = i / 4;
        s[8*(15-i) +: 8] = t[8*(15-(row + 4*((col + row) % 4))) +: 8];
      end
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[8*(15-4*c) +: 8];
          a1 = s[8*(14-4*c) +: 8];
          a2 = s[8*(13-4*c) +: 8];
          a3 = s[8*(12-4*c) +: 8];
          s[8*(15-4*c) +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[8*(14-4*c) +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[8*(13-4*c) +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[8*(12-4*c) +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      s = s ^ rk_mem[r];
    end
    return s;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back(drv_exp);
      if (out_valid && out_ready) begin
        check("sb_nonempty", 128'(exp_q.size() != 0), 128'd1);
        if (exp_q.size() != 0) check("sb_pt", pt_out, exp_q.pop_front());
        n_out++;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds in_valid until an accept edge; returns at the sample point after it.
  task automatic send(input logic [127:0] ct, input logic [127:0] exp, input string tag);
    logic rdy;
    int   k = 0;
    in_valid = 1'b1;
    ct_in    = ct;
    drv_exp  = exp;
    do begin
      rdy = in_ready;
      step();
      k++;
    end while (!rdy && k < 60);
    in_valid = 1'b0;
    check({tag, "_accept"}, 128'(rdy), 128'd1);
  endtask

  task automatic wait_out(input string tag);
    int k = 0;
    while (!out_valid && k < 40) begin
      step();
      k++;
    end
    check({tag, "_out_valid"}, 128'(out_valid), 128'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] cts [4];
    logic [127:0] pts [4];
    int           sent, n0, cyc;
    logic         acc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ct_in     = '0;
    drv_exp   = '0;
    build_sbox();
    expand_key(C1_KEY);

    repeat (3) step();
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_pt_out", pt_out, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rel_in_ready", 128'(in_ready), 128'd1);
    check("rel_out_valid", 128'(out_valid), 128'd0);
    check("rel_pt_out", pt_out, 128'd0);
    check("idle_rk_idx", 128'(rk_idx), 128'd10);

    // C.1 with exact latency and rk_idx trace.
    out_ready = 1'b1;
    send(C1_CT, C1_PT, "c1");
    for (int j = 0; j < 10; j++) begin
      check($sformatf("c1_rk_idx_%0d", j), 128'(rk_idx), 128'(9 - j));
      check($sformatf("c1_no_valid_%0d", j), 128'(out_valid), 128'd0);
      check($sformatf("c1_in_ready_%0d", j), 128'(in_ready), 128'd0);
      step();
    end
    check("c1_latency_valid", 128'(out_valid), 128'd1);
    check("c1_pt", pt_out, C1_PT);
    step();
    check("c1_post_in_ready", 128'(in_ready), 128'd1);
    check("c1_post_out_valid", 128'(out_valid), 128'd0);
    check("c1_post_rk_idx", 128'(rk_idx), 128'd10);

    // FIPS-197 Appendix B.
    expand_key(B_KEY);
    send(B_CT, B_PT, "appb");
    wait_out("appb");
    check("appb_pt", pt_out, B_PT);
    step();

    // Backpressure in DONE with an ignored in_valid pulse.
    expand_key(C1_KEY);
    out_ready = 1'b0;
    send(C1_CT, C1_PT, "bp");
    wait_out("bp");
    for (int j = 0; j < 5; j++) begin
      check($sformatf("bp_valid_%0d", j), 128'(out_valid), 128'd1);
      check($sformatf("bp_pt_%0d", j), pt_out, C1_PT);
      check($sformatf("bp_in_ready_%0d", j), 128'(in_ready), 128'd0);
      if (j == 2) begin
        in_valid = 1'b1;
        ct_in    = B_CT;
        drv_exp  = 128'hdead_beef;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_after_in_ready", 128'(in_ready), 128'd1);
    check("bp_after_out_valid", 128'(out_valid), 128'd0);
    check("bp_queue_empty", 128'(exp_q.size()), 128'd0);

    // Reset while rk_idx == 5.
    send(C1_CT, C1_PT, "mrst");
    repeat (4) step();
    check("mrst_rk_idx", 128'(rk_idx), 128'd5);
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 128'(out_valid), 128'd0);
    check("mrst_pt_out", pt_out, 128'd0);
    check("mrst_in_ready", 128'(in_ready), 128'd1);
    exp_q.delete();
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      step();
      check("mrst_no_stale_valid", 128'(out_valid), 128'd0);
    end
    check("mrst_rel_pt_out", pt_out, 128'd0);
    send(C1_CT, C1_PT, "mrst_c1");
    wait_out("mrst_c1");
    check("mrst_c1_pt", pt_out, C1_PT);
    step();

    // Back-to-back random blocks with random gaps on both sides.
    expand_key({$urandom, $urandom, $urandom, $urandom});
    for (int b = 0; b < 4; b++) begin
      pts[b] = {$urandom, $urandom, $urandom, $urandom};
      cts[b] = aes_enc(pts[b]);
    end
    sent = 0;
    n0   = n_out;
    cyc  = 0;
    while ((n_out - n0) < 4 && cyc < 600) begin
      if (sent < 4 && !in_valid && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b1;
        ct_in    = cts[sent];
        drv_exp  = pts[sent];
      end
      out_ready = 1'($urandom_range(0, 1));
      acc = in_valid && in_ready;
      step();
      cyc++;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    check("b2b_sent", 128'(sent), 128'd4);
    check("b2b_outputs", 128'(n_out - n0), 128'd4);
    check("b2b_queue_empty", 128'(exp_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
